secded_codec_pipe: RTL and testbench
====================================

SECDED_CODEC_PIPE -- requirements
Module: secded_codec_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 11, data word width; legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16, width of each error counter.
REQ-003 SHALL derive localparam R as the smallest r with 2^r >= DATA_W+r+1, and PAR_W = R+1 (DATA_W=11 gives R=4, PAR_W=5).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous and active-low.
REQ-006 SHALL have port mode_i  in  1  0 = encode, 1 = decode/correct; qualified by in_valid.
REQ-007 SHALL have ports in_valid (in, 1) and in_ready (out, 1), the input handshake.
REQ-008 SHALL have port in_data  in  DATA_W  data word to encode, or received data to check.
REQ-009 SHALL have port in_par  in  PAR_W  received parity bits; ignored in encode.
REQ-010 SHALL have ports out_valid (out, 1) and out_ready (in, 1), the output handshake.
REQ-011 SHALL have ports out_data (out, DATA_W) and out_par (out, PAR_W), the resulting codeword.
REQ-012 SHALL have ports out_sec and out_ded, each out, 1, flagging a single corrected error and a double detected error.
REQ-013 SHALL have port cnt_clr  in  1  synchronous clear of both counters.
REQ-014 SHALL have ports sec_cnt and ded_cnt, each out, CNT_W, saturating error counters.

Function
REQ-015 SHALL place the codeword in positions 1..DATA_W+R.
- Hamming parity bit k sits at position 2^k.
- Data bits fill the remaining positions in ascending order, data[0] at position 3.
REQ-016 SHALL compute par[k], k<R, as the XOR of all data bits whose position has bit k set.
REQ-017 SHALL compute par[R] as the XOR of all data bits and par[R-1:0] (even overall parity).
- For DATA_W=11 this is bit-identical to the existing (16,11) encoder.
REQ-018 SHALL, in decode mode, compute:
- syndrome s = recomputed par[R-1:0] XOR in_par[R-1:0];
- o = XOR of all in_data and in_par bits.
REQ-019 SHALL classify a decode result as follows:
- s=0, o=0: clean.
- o=1, s=0: overall bit in error; SEC.
- o=1, s a power of two: par[log2 s] in error; SEC.
- o=1, s another position <= DATA_W+R: that data bit is inverted; SEC.
- o=1, s > DATA_W+R: DED.
- s!=0, o=0: DED.
REQ-020 SHALL output the corrected data and recomputed-consistent parity on SEC, and pass in_data/in_par unchanged on DED.
REQ-021 SHALL drive out_sec=out_ded=0 on every encode result.
REQ-022 SHALL register results in one output stage: an accepted input appears on outputs the next cycle (latency 1).
REQ-023 SHALL drive in_ready = !out_valid || out_ready, combinationally, so full throughput is one word per cycle.
REQ-024 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid after a consumed word when no new input is accepted in the same cycle.
REQ-026 SHALL increment sec_cnt/ded_cnt in the cycle a SEC/DED result is loaded into the output stage.
REQ-027 SHALL saturate each counter at all-ones.
REQ-028 SHALL give cnt_clr priority: the counter goes to 0 and a coincident increment is dropped.

Reset
REQ-029 SHALL, while rst_n=0, immediately force out_valid, out_data, out_par, out_sec, out_ded, sec_cnt and ded_cnt to 0; in_ready is then 1.
REQ-030 SHALL discard any in-flight word on reset mid-stream and resume on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL cover encode, DATA_W=11: in_data=0x001 -> out_par=0x13, out_data=0x001, flags 0; in_data=0x000 -> out_par=0x00.
REQ-032 SHALL cover decode single data error: data=0x000, par=0x13 -> out_data=0x001, out_par=0x13, out_sec=1, sec_cnt +1.
REQ-033 SHALL cover decode overall-bit error: data=0x001, par=0x03 -> out_data=0x001, out_par=0x13, out_sec=1.
REQ-034 SHALL cover decode double error: data=0x002, par=0x13 -> out_ded=1, out_data=0x002, out_par=0x13, ded_cnt +1.
REQ-035 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no word lost or duplicated.
REQ-036 SHALL cover counters and reset: with CNT_W=2, 5 SEC words -> sec_cnt=3; cnt_clr together with a SEC word -> sec_cnt=0; rst_n low mid-stream -> all outputs 0.

Source files
------------

// File: rtl/secded_codec_pipe_if.sv
// -----------------------------------------------------------------------------
// secded_codec_pipe_if
// Handshake bundle for the SECDED encode/decode pipe.
//   Input side : mode_i, in_valid, in_ready, in_data, in_par
//   Output side: out_valid, out_ready, out_data, out_par, out_sec, out_ded
// master = the agent feeding words in and consuming results,
// slave  = the codec itself.
// PAR_W must match the codec's derived parity width (R+1).
// -----------------------------------------------------------------------------
interface secded_codec_pipe_if #(
  parameter int DATA_W = 11,
  parameter int PAR_W  = 5
);
  logic              mode_i;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PAR_W-1:0]  in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_par;
  logic              out_sec;
  logic              out_ded;

  modport master (
    output mode_i, in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_sec, out_ded
  );

  modport slave (
    input  mode_i, in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_par, out_sec, out_ded
  );
endinterface

// File: rtl/secded_codec_pipe.sv
// -----------------------------------------------------------------------------
// secded_codec_pipe
// Single-stage pipelined extended-Hamming (SECDED) encoder / corrector.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   cnt_clr  : synchronous clear of both error counters (wins over increment)
//   sec_cnt  : saturating count of single-error-corrected results
//   ded_cnt  : saturating count of double-error-detected results
//   bus      : handshake bundle (slave side), see secded_codec_pipe_if
// Codeword layout: positions 1..DATA_W+R, Hamming parity k at position 2^k,
// data bits fill the other positions in ascending order (data[0] at 3),
// par[R] is even parity over all data and Hamming parity bits.
// -----------------------------------------------------------------------------
module secded_codec_pipe #(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   sec_cnt,
  output logic [CNT_W-1:0]   ded_cnt,
  secded_codec_pipe_if.slave bus
);

  // Smallest r with 2^r >= dw + r + 1 (scan downwards so the last hit wins).
  function automatic int calc_r(input int dw);
    int r;
    r = 32'sd7;
    for (int c = 32'sd7; c >= 32'sd1; c--) begin
      if ((32'sd1 << c) >= (dw + c + 32'sd1)) r = c;
    end
    return r;
  endfunction

  localparam int R     = calc_r(DATA_W);
  localparam int PAR_W = R + 32'sd1;
  localparam int N     = DATA_W + R;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Codeword position of data bit idx: the idx-th non-power-of-two from 3 up.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 32'sd0;
    cnt = 32'sd0;
    for (int p = 32'sd3; p <= N; p++) begin
      if ((p & (p - 32'sd1)) != 32'sd0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Hamming parity bits par[R-1:0] of a data word.
  function automatic logic [R-1:0] hamming_par(input logic [DATA_W-1:0] d);
    logic [R-1:0] hp;
    int           pos;
    hp = '0;
    for (int i = 32'sd0; i < DATA_W; i++) begin
      pos = data_pos(i);
      for (int k = 32'sd0; k < R; k++) begin
        if (pos[k]) hp[k] = hp[k] ^ d[i];
      end
    end
    return hp;
  endfunction

  // Full parity field: overall even-parity bit on top of the Hamming bits.
  function automatic logic [PAR_W-1:0] full_par(input logic [DATA_W-1:0] d);
    logic [R-1:0] hp;
    hp = hamming_par(d);
    return {^{d, hp}, hp};
  endfunction

  // Invert the data bit sitting at codeword position s (no-op for parity positions).
  function automatic logic [DATA_W-1:0] flip_data(input logic [DATA_W-1:0] d,
                                                  input logic [R-1:0]      s);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 32'sd0; i < DATA_W; i++) begin
      if (data_pos(i) == int'(s)) r[i] = ~r[i];
    end
    return r;
  endfunction

  logic [R-1:0]      hp_s;
  logic [R-1:0]      syn_s;
  logic              ovr_s;
  logic [DATA_W-1:0] fix_data_s;
  logic [DATA_W-1:0] nxt_data_s;
  logic [PAR_W-1:0]  nxt_par_s;
  logic              nxt_sec_s;
  logic              nxt_ded_s;
  logic              in_ready_s;
  logic              load_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [PAR_W-1:0]  out_par_r;
  logic              out_sec_r;
  logic              out_ded_r;
  logic [CNT_W-1:0]  sec_cnt_r;
  logic [CNT_W-1:0]  ded_cnt_r;

  // Output stage can take a word when empty or being drained this cycle.
  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign load_s     = bus.in_valid && in_ready_s;

  // Encode / syndrome classification / correction datapath.
  always_comb begin
    hp_s       = hamming_par(bus.in_data);
    syn_s      = hp_s ^ bus.in_par[R-1:0];
    ovr_s      = ^{bus.in_data, bus.in_par};
    fix_data_s = flip_data(bus.in_data, syn_s);
    nxt_data_s = bus.in_data;
    nxt_par_s  = bus.in_par;
    nxt_sec_s  = 1'b0;
    nxt_ded_s  = 1'b0;
    if (!bus.mode_i) begin
      nxt_par_s = {^{bus.in_data, hp_s}, hp_s};
    end else if (ovr_s) begin
      // Odd overall parity: one flipped bit, unless the syndrome points
      // past the end of the codeword.
      if (int'(syn_s) > N) begin
        nxt_ded_s = 1'b1;
      end else begin
        // s=0 or a power of two leaves the data alone; parity is rebuilt.
        nxt_sec_s  = 1'b1;
        nxt_data_s = fix_data_s;
        nxt_par_s  = full_par(fix_data_s);
      end
    end else if (syn_s != '0) begin
      nxt_ded_s = 1'b1;
    end else begin
      nxt_data_s = bus.in_data;
    end
  end

  // Output register: load on accept, drop valid once consumed, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_par_r   <= '0;
      out_sec_r   <= 1'b0;
      out_ded_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= nxt_data_s;
      out_par_r   <= nxt_par_s;
      out_sec_r   <= nxt_sec_s;
      out_ded_r   <= nxt_ded_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Saturating SEC/DED counters, clear takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_r <= '0;
      ded_cnt_r <= '0;
    end else if (cnt_clr) begin
      sec_cnt_r <= '0;
      ded_cnt_r <= '0;
    end else begin
      if (load_s && nxt_sec_s && (sec_cnt_r != CNT_MAX)) sec_cnt_r <= sec_cnt_r + CNT_ONE;
      if (load_s && nxt_ded_s && (ded_cnt_r != CNT_MAX)) ded_cnt_r <= ded_cnt_r + CNT_ONE;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_par   = out_par_r;
  assign bus.out_sec   = out_sec_r;
  assign bus.out_ded   = out_ded_r;
  assign sec_cnt       = sec_cnt_r;
  assign ded_cnt       = ded_cnt_r;

endmodule

// File: tb/tb_secded_codec_pipe.sv
// -----------------------------------------------------------------------------
// tb_secded_codec_pipe
// Scoreboard bench for secded_codec_pipe (DATA_W=11, CNT_W=2). The driver
// pushes the reference-model result of every accepted word; a separate
// monitor pops and compares whenever a word is consumed and also checks
// output stability while stalled. The reference model works on an explicit
// codeword bit array (syndrome = XOR of indices of set bits).
// -----------------------------------------------------------------------------
module tb_secded_codec_pipe;
  localparam int DW   = 11;
  localparam int PW   = 5;
  localparam int CW   = 2;
  localparam int NPOS = 15;
  localparam int CMAX = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic          sec;
    logic          ded;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cnt_clr;
  logic [CW-1:0] sec_cnt;
  logic [CW-1:0] ded_cnt;

  secded_codec_pipe_if #(.DATA_W(DW), .PAR_W(PW)) bus ();

  secded_codec_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_clr (cnt_clr),
    .sec_cnt (sec_cnt),
    .ded_cnt (ded_cnt),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_sec = 0;
  int   exp_ded = 0;

  function automatic bit is_pow2(int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Reference encoder: lay data into the codeword array, then parity k covers
  // every position whose index has bit k set.
  function automatic logic [PW-1:0] ref_encode(logic [DW-1:0] d);
    bit            cw [0:NPOS];
    logic [DW-1:0] t;
    logic [PW-1:0] p;
    bit            ov;
    t = d;
    for (int pos = 0; pos <= NPOS; pos++) cw[pos] = 1'b0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if (!is_pow2(pos)) begin
        cw[pos] = t[0];
        t = t >> 1;
      end
    end
    p = '0;
    for (int k = 0; k < 4; k++)
      for (int pos = 1; pos <= NPOS; pos++)
        if (((pos >> k) & 1) != 0) p[k] = p[k] ^ cw[pos];
    ov = 1'b0;
    for (int pos = 1; pos <= NPOS; pos++) ov = ov ^ cw[pos];
    for (int k = 0; k < 4; k++) ov = ov ^ p[k];
    p[4] = ov;
    return p;
  endfunction

  function automatic exp_t ref_model(bit m, logic [DW-1:0] d, logic [PW-1:0] p);
    exp_t          e;
    bit            cw [0:NPOS];
    logic [DW-1:0] t;
    logic [PW-1:0] pp;
    logic [DW-1:0] nd;
    int            s;
    bit            o;
    if (!m) begin
      e = '{d: d, p: ref_encode(d), sec: 1'b0, ded: 1'b0};
      return e;
    end
    t  = d;
    pp = p;
    cw[0] = 1'b0;
    for (int pos = 1; pos <= NPOS; pos++) begin
      if (is_pow2(pos)) begin
        cw[pos] = pp[0];
        pp = pp >> 1;
      end else begin
        cw[pos] = t[0];
        t = t >> 1;
      end
    end
    s = 0;
    o = p[4];
    for (int pos = 1; pos <= NPOS; pos++) begin
      if (cw[pos]) s = s ^ pos;
      o = o ^ cw[pos];
    end
    if (!o && s == 0) begin
      e = '{d: d, p: p, sec: 1'b0, ded: 1'b0};
    end else if (o && s <= NPOS) begin
      if (s != 0) cw[s] = ~cw[s];
      nd = '0;
      for (int pos = NPOS; pos >= 1; pos--)
        if (!is_pow2(pos)) nd = {nd[DW-2:0], cw[pos]};
      e = '{d: nd, p: ref_encode(nd), sec: 1'b1, ded: 1'b0};
    end else begin
      e = '{d: d, p: p, sec: 1'b0, ded: 1'b1};
    end
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One clock of stimulus; records accepted words and tracks counter model.
  task automatic cycle(bit v, bit m, logic [DW-1:0] d, logic [PW-1:0] p,
                       bit ordy, bit clr, exp_t e);
    bit acc;
    @(negedge clk);
    bus.in_valid  = v;
    bus.mode_i    = m;
    bus.in_data   = d;
    bus.in_par    = p;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    #1;
    check("out_valid", bus.out_valid, q.size() != 0);
    check("in_ready", bus.in_ready, (q.size() == 0) || ordy);
    acc = v && bus.in_ready;
    if (acc) q.push_back(e);
    if (clr) begin
      exp_sec = 0;
      exp_ded = 0;
    end else if (acc) begin
      if (e.sec && exp_sec < CMAX) exp_sec++;
      if (e.ded && exp_ded < CMAX) exp_ded++;
    end
    @(posedge clk);
    #1;
    check("sec_cnt", sec_cnt, exp_sec);
    check("ded_cnt", ded_cnt, exp_ded);
  endtask

  task automatic idle(bit ordy);
    cycle(1'b0, 1'b0, '0, '0, ordy, 1'b0, exp_t'(0));
  endtask

  task automatic send(bit m, logic [DW-1:0] d, logic [PW-1:0] p, bit ordy, bit clr);
    cycle(1'b1, m, d, p, ordy, clr, ref_model(m, d, p));
  endtask

  // Monitor: compare every consumed word; outputs must not move while stalled.
  initial begin : monitor
    exp_t e;
    exp_t snap;
    exp_t act;
    bit   stalled;
    stalled = 1'b0;
    snap    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        act = '{d: bus.out_data, p: bus.out_par, sec: bus.out_sec, ded: bus.out_ded};
        if (stalled) check("stall_stable", act, snap);
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL word: unexpected output data=0x%0h par=0x%0h, expected none", act.d, act.p);
          end else begin
            e = q.pop_front();
            if (act !== e) begin
              errors++;
              $display("FAIL word: got data=0x%0h par=0x%0h sec=%b ded=%b, expected data=0x%0h par=0x%0h sec=%b ded=%b",
                       act.d, act.p, act.sec, act.ded, e.d, e.p, e.sec, e.ded);
            end
          end
        end
        stalled = bus.out_valid && !bus.out_ready;
        snap    = act;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [DW-1:0]    d;
    logic [PW-1:0]    p;
    logic [DW+PW-1:0] cwv;
    bit               m;
    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode_i    = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_data", bus.out_data, 11'h000);
    check("rst_sec_cnt", sec_cnt, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    cycle(1'b1, 1'b0, 11'h001, 5'h00, 1'b1, 1'b0, '{d: 11'h001, p: 5'h13, sec: 1'b0, ded: 1'b0});
    cycle(1'b1, 1'b0, 11'h000, 5'h1f, 1'b1, 1'b0, '{d: 11'h000, p: 5'h00, sec: 1'b0, ded: 1'b0});
    cycle(1'b1, 1'b1, 11'h000, 5'h13, 1'b1, 1'b0, '{d: 11'h001, p: 5'h13, sec: 1'b1, ded: 1'b0});
    cycle(1'b1, 1'b1, 11'h001, 5'h03, 1'b1, 1'b0, '{d: 11'h001, p: 5'h13, sec: 1'b1, ded: 1'b0});
    cycle(1'b1, 1'b1, 11'h002, 5'h13, 1'b1, 1'b0, '{d: 11'h002, p: 5'h13, sec: 1'b0, ded: 1'b1});
    idle(1'b1);

    // Backpressure: output held for 3 cycles while new words wait.
    send(1'b0, 11'h555, 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 11'h2aa, 5'h00, 1'b0, 1'b0);
    send(1'b0, 11'h2aa, 5'h00, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Counter saturation and clear priority.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, exp_t'(0));
    for (int i = 0; i < 5; i++) send(1'b1, 11'h000, 5'h13, 1'b1, 1'b0);
    idle(1'b1);
    check("sec_sat", sec_cnt, 2'd3);
    send(1'b1, 11'h000, 5'h13, 1'b1, 1'b1);
    check("sec_clr_prio", sec_cnt, 2'd0);
    idle(1'b1);

    // Reset mid-stream with a stalled word and non-zero counters.
    send(1'b1, 11'h000, 5'h13, 1'b1, 1'b0);
    send(1'b1, 11'h002, 5'h13, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_out_data", bus.out_data, 11'h000);
    check("mid_rst_out_par", bus.out_par, 5'h00);
    check("mid_rst_flags", {bus.out_sec, bus.out_ded}, 2'b00);
    check("mid_rst_cnts", {sec_cnt, ded_cnt}, 4'h0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    q.delete();
    exp_sec = 0;
    exp_ded = 0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with 0..2 injected bit flips in decode words.
    for (int n = 0; n < 400; n++) begin
      m = 1'($urandom_range(1, 0));
      d = DW'($urandom);
      p = ref_encode(d);
      if ($urandom_range(3, 0) == 0) p = PW'($urandom);
      cwv = {d, p};
      repeat ($urandom_range(2, 0)) cwv = cwv ^ ((DW+PW)'(1) << $urandom_range(DW+PW-1, 0));
      cycle(($urandom_range(3, 0) != 0), m, cwv[DW+PW-1:PW], cwv[PW-1:0],
            ($urandom_range(3, 0) != 0), ($urandom_range(19, 0) == 0),
            ref_model(m, cwv[DW+PW-1:PW], cwv[PW-1:0]));
    end

    for (int i = 0; i < 3; i++) idle(1'b1);
    check("drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
